// File: rtl/accel_matrix_loader.sv
// Matrix loader: streams matrices A and B into an accelerator slave over a
// Wishbone master port, framed by operation-register writes and a kick read.
module accel_matrix_loader #(
  parameter int MAX_DIM     = 15,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        wishbone_clk_i,
  input  logic        wishbone_rst_i,
  input  logic        cmd_start,
  input  logic [14:0] cmd_rows_a,
  input  logic [14:0] cmd_cols_a,
  input  logic [14:0] cmd_rows_b,
  input  logic [14:0] cmd_cols_b,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic        wishbone_stb_o,
  input  logic        wishbone_ack_i,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [14:0] LMAX = 15'(MAX_DIM);

  typedef enum logic [2:0] {
    IDLE, WR_OP, LOAD_A, LOAD_B, GO, KICK, FIN
  } state_t;

  state_t            r_state;
  logic [14:0]       r_rows_a, r_cols_a;
  logic [14:0]       r_rows_b, r_cols_b;
  logic [14:0]       r_row, r_col;
  logic [2:0]        r_idx;
  logic              r_last;
  logic [TO_W-1:0]   r_to;
  logic [31:0]       r_addr, r_data;
  logic              r_we, r_stb;
  logic              r_busy, r_done, r_err;
  logic [1:0]        r_err_code;

  logic              w_bad;
  logic              w_load;
  logic [14:0]       w_rows, w_cols;
  logic [1:0]        w_tag;
  logic [31:0]       w_op_data;
  logic              w_hs;

  assign w_bad = (cmd_rows_a == '0) || (cmd_cols_a == '0) ||
                 (cmd_rows_b == '0) || (cmd_cols_b == '0) ||
                 (cmd_rows_a > LMAX) || (cmd_cols_a > LMAX) ||
                 (cmd_rows_b > LMAX) || (cmd_cols_b > LMAX) ||
                 (cmd_cols_a != cmd_rows_b);

  assign w_load = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_rows = (r_state == LOAD_A) ? r_rows_a : r_rows_b;
  assign w_cols = (r_state == LOAD_A) ? r_cols_a : r_cols_b;
  assign w_tag  = (r_state == LOAD_A) ? 2'b01 : 2'b10;
  assign w_hs   = w_load && !r_stb && s_valid;

  always_comb begin
    w_op_data = 32'd1;
    unique case (r_idx)
      3'd1:    w_op_data = {17'd0, r_cols_a};
      3'd2:    w_op_data = {17'd0, r_rows_a};
      3'd3:    w_op_data = {17'd0, r_cols_b};
      3'd4:    w_op_data = {17'd0, r_rows_b};
      default: w_op_data = 32'd1;
    endcase
  end

  always_ff @(posedge wishbone_clk_i or negedge wishbone_rst_i) begin
    if (!wishbone_rst_i) begin
      r_state    <= IDLE;
      r_rows_a   <= '0;
      r_cols_a   <= '0;
      r_rows_b   <= '0;
      r_cols_b   <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_idx      <= '0;
      r_last     <= 1'b0;
      r_to       <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
      r_stb      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // A write still waiting for its ack: age it, abort on expiry.
      if (r_stb && r_we && !wishbone_ack_i) begin
        if (r_to == TO_LAST) begin
          r_stb      <= 1'b0;
          r_we       <= 1'b0;
          r_err      <= 1'b1;
          r_err_code <= 2'd2;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end else begin
          r_to <= r_to + 1'b1;
        end
      end else begin
        unique case (r_state)
          IDLE: begin
            if (cmd_start) begin
              if (w_bad) begin
                r_err      <= 1'b1;
                r_err_code <= 2'd1;
              end else begin
                r_rows_a <= cmd_rows_a;
                r_cols_a <= cmd_cols_a;
                r_rows_b <= cmd_rows_b;
                r_cols_b <= cmd_cols_b;
                r_idx    <= '0;
                r_busy   <= 1'b1;
                r_state  <= WR_OP;
              end
            end
          end
          WR_OP: begin
            if (r_stb) begin
              r_stb <= 1'b0;
              r_we  <= 1'b0;
              if (r_idx == 3'd4) begin
                r_row   <= '0;
                r_col   <= '0;
                r_state <= LOAD_A;
              end else begin
                r_idx <= r_idx + 3'd1;
              end
            end else begin
              r_addr <= {29'd0, r_idx};
              r_data <= w_op_data;
              r_stb  <= 1'b1;
              r_we   <= 1'b1;
              r_to   <= '0;
            end
          end
          LOAD_A, LOAD_B: begin
            if (r_stb) begin
              r_stb <= 1'b0;
              r_we  <= 1'b0;
              if (r_last) begin
                r_row   <= '0;
                r_col   <= '0;
                r_state <= (r_state == LOAD_A) ? LOAD_B : GO;
              end
            end else if (w_hs) begin
              r_addr <= {w_tag, r_row, r_col};
              r_data <= s_data;
              r_stb  <= 1'b1;
              r_we   <= 1'b1;
              r_to   <= '0;
              r_last <= (r_row == w_rows - 15'd1) &&
                        (r_col == w_cols - 15'd1);
              if (r_col == w_cols - 15'd1) begin
                r_col <= '0;
                r_row <= r_row + 15'd1;
              end else begin
                r_col <= r_col + 15'd1;
              end
            end
          end
          GO: begin
            if (r_stb) begin
              r_stb   <= 1'b0;
              r_we    <= 1'b0;
              r_state <= KICK;
            end else begin
              r_addr <= 32'd5;
              r_data <= 32'hFFFF_FFFF;
              r_stb  <= 1'b1;
              r_we   <= 1'b1;
              r_to   <= '0;
            end
          end
          KICK: begin
            // One-cycle read strobe; the slave does not ack it.
            if (r_stb) begin
              r_stb   <= 1'b0;
              r_state <= FIN;
            end else begin
              r_addr <= '0;
              r_we   <= 1'b0;
              r_stb  <= 1'b1;
            end
          end
          FIN: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign s_ready         = w_load && !r_stb;
  assign wishbone_addr_o = r_addr;
  assign wishbone_data_o = r_data;
  assign wishbone_we_o   = r_we;
  assign wishbone_stb_o  = r_stb;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;
  assign err_code        = r_err_code;

endmodule

// File: tb/tb_accel_matrix_loader.sv
// Bench for accel_matrix_loader: random matrices and latencies checked
// against an expected transaction list built from the address map.
module tb_accel_matrix_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_start;
  logic [14:0] ra_i, ca_i, rb_i, cb_i;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [31:0] addr, wdata;
  logic        we, stb;
  logic        ack = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  accel_matrix_loader dut (
    .wishbone_clk_i  (clk),
    .wishbone_rst_i  (rst_n),
    .cmd_start       (cmd_start),
    .cmd_rows_a      (ra_i),
    .cmd_cols_a      (ca_i),
    .cmd_rows_b      (rb_i),
    .cmd_cols_b      (cb_i),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .s_ready         (s_ready),
    .wishbone_addr_o (addr),
    .wishbone_data_o (wdata),
    .wishbone_we_o   (we),
    .wishbone_stb_o  (stb),
    .wishbone_ack_i  (ack),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .err_code        (err_code)
  );

  int checks = 0;
  int passed = 0;

  // Slave: acks a write ack_lat cycles after its strobe is seen.
  logic ack_en = 1'b1;
  logic stray = 1'b0;
  int   ack_lat = 1;
  int   scnt = 0;
  always @(posedge clk) begin
    if (stb && we && !ack && ack_en) begin
      if (scnt >= ack_lat - 1) begin
        ack  <= 1'b1;
        scnt <= 0;
      end else begin
        scnt <= scnt + 1;
      end
    end else begin
      ack <= stray && !stb;
      if (!stb) scnt <= 0;
    end
  end

  logic [63:0] wr_log[$];
  int kicks = 0, dones = 0, errs = 0, viol = 0, rises = 0;
  int run = 0, last_run = 0;
  logic prev_hs = 1'b0, prev_stb = 1'b0;
  always @(negedge clk) begin
    if (stb && we && ack) wr_log.push_back({addr, wdata});
    if (stb && !we) kicks <= kicks + 1;
    if (done) dones <= dones + 1;
    if (err) errs <= errs + 1;
    if (stb && prev_hs) viol <= viol + 1;
    if (stb && !prev_stb) rises <= rises + 1;
    prev_hs  <= stb && ack;
    prev_stb <= stb;
    if (stb) run <= run + 1;
    else begin
      if (run != 0) last_run <= run;
      run <= 0;
    end
  end

  logic [31:0] stream[$];
  logic [63:0] exp_q[$];

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic build(input int ra, input int ca, input int rb, input int cb);
    logic [31:0] d;
    stream.delete();
    exp_q.delete();
    exp_q.push_back({32'd0, 32'd1});
    exp_q.push_back({32'd1, 32'(ca)});
    exp_q.push_back({32'd2, 32'(ra)});
    exp_q.push_back({32'd3, 32'(cb)});
    exp_q.push_back({32'd4, 32'(rb)});
    for (int k = 0; k < ra * ca; k++) begin
      d = $urandom;
      stream.push_back(d);
      exp_q.push_back({32'h4000_0000 + 32'((k / ca) * 32768 + k % ca), d});
    end
    for (int k = 0; k < rb * cb; k++) begin
      d = $urandom;
      stream.push_back(d);
      exp_q.push_back({32'h8000_0000 + 32'((k / cb) * 32768 + k % cb), d});
    end
    exp_q.push_back({32'd5, 32'hFFFF_FFFF});
  endtask

  task automatic issue(input int ra, input int ca, input int rb, input int cb);
    ra_i = 15'(ra); ca_i = 15'(ca);
    rb_i = 15'(rb); cb_i = 15'(cb);
    cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0;
  endtask

  task automatic do_gap(input int len, input string nm);
    int r0;
    tick; tick; tick;
    r0 = rises;
    ra_i = 15'd1; ca_i = 15'd1; rb_i = 15'd1; cb_i = 15'd1;
    cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0;
    for (int j = 4; j < len; j++) tick;
    checks++;
    if (rises !== r0)
      $display("FAIL %s gap_stb: got %0d strobes want 0", nm, rises - r0);
    else passed++;
  endtask

  task automatic feed(input int gap_at, input int gap_len, input string nm);
    int i = 0;
    int budget = 0;
    bit gapped = 1'b0;
    while (i < stream.size() && budget < 4000) begin
      if (!gapped && i == gap_at) begin
        gapped  = 1'b1;
        s_valid = 1'b0;
        do_gap(gap_len, nm);
      end
      s_valid = 1'b1;
      s_data  = stream[i];
      if (s_ready) i++;
      tick;
      budget++;
    end
    s_valid = 1'b0;
    if (i < stream.size()) begin
      checks++;
      $display("FAIL %s feed: got %0d elements want %0d", nm, i, stream.size());
    end
  endtask

  task automatic run_cmd(input int ra, input int ca, input int rb, input int cb,
                         input int gap_at, input int gap_len, input string nm);
    int n0, d0, e0, k0, v0, b;
    n0 = wr_log.size();
    d0 = dones; e0 = errs; k0 = kicks; v0 = viol;
    build(ra, ca, rb, cb);
    issue(ra, ca, rb, cb);
    checks++;
    if (busy !== 1'b1) $display("FAIL %s busy: got %b want 1", nm, busy);
    else passed++;
    feed(gap_at, gap_len, nm);
    b = 0;
    while (dones == d0 && b < 3000) begin tick; b++; end
    tick; tick;
    checks++;
    if (dones !== d0 + 1) $display("FAIL %s done: got %0d pulses want 1", nm, dones - d0);
    else passed++;
    checks++;
    if (wr_log.size() - n0 !== exp_q.size())
      $display("FAIL %s nwr: got %0d want %0d", nm, wr_log.size() - n0, exp_q.size());
    else passed++;
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (n0 + k >= wr_log.size())
        $display("FAIL %s wr[%0d]: got none want %h", nm, k, exp_q[k]);
      else if (wr_log[n0 + k] !== exp_q[k])
        $display("FAIL %s wr[%0d]: got %h want %h", nm, k, wr_log[n0 + k], exp_q[k]);
      else passed++;
    end
    checks++;
    if (kicks !== k0 + 1) $display("FAIL %s kick: got %0d want 1", nm, kicks - k0);
    else passed++;
    checks++;
    if (errs !== e0 || viol !== v0 || busy !== 1'b0)
      $display("FAIL %s tail: got err=%0d sp=%0d busy=%b want 0 0 0",
               nm, errs - e0, viol - v0, busy);
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    s_valid = 1'b1;
    s_data = 32'hDEAD_BEEF;
    cmd_start = 1'b0;
    ra_i = '0; ca_i = '0; rb_i = '0; cb_i = '0;
    tick; tick;
    checks++;
    if ({stb, we, s_ready, busy, done, err} !== 6'b0)
      $display("FAIL reset_ctl: got %b want 000000", {stb, we, s_ready, busy, done, err});
    else passed++;
    checks++;
    if ({addr, wdata, err_code} !== 66'b0)
      $display("FAIL reset_bus: got %h %h %0d want 0", addr, wdata, err_code);
    else passed++;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_idle_valid;
    int r0 = rises;
    s_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick;
      checks++;
      if (s_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", s_ready);
      else passed++;
    end
    s_valid = 1'b0;
    checks++;
    if (rises !== r0) $display("FAIL idle_stb: got %0d want 0", rises - r0);
    else passed++;
  endtask

  task automatic test_reject(input int ra, input int ca, input int rb, input int cb,
                             input string nm);
    int e0 = errs;
    int r0 = rises;
    issue(ra, ca, rb, cb);
    tick; tick;
    checks++;
    if (errs !== e0 + 1 || err_code !== 2'd1)
      $display("FAIL %s err: got %0d pulses code %0d want 1 code 1", nm, errs - e0, err_code);
    else passed++;
    checks++;
    if (busy !== 1'b0 || rises !== r0)
      $display("FAIL %s idle: got busy=%b stb=%0d want 0 0", nm, busy, rises - r0);
    else passed++;
  endtask

  task automatic test_timeout;
    int e0 = errs;
    int d0 = dones;
    int b = 0;
    ack_en = 1'b0;
    issue(1, 1, 1, 1);
    while (errs == e0 && b < 1000) begin tick; b++; end
    tick; tick;
    checks++;
    if (last_run !== 255) $display("FAIL to_len: got %0d want 255", last_run);
    else passed++;
    checks++;
    if (errs !== e0 + 1 || err_code !== 2'd2 || busy !== 1'b0 || dones !== d0)
      $display("FAIL to_err: got err=%0d code=%0d busy=%b want 1 2 0",
               errs - e0, err_code, busy);
    else passed++;
    ack_en = 1'b1;
    run_cmd(2, 3, 3, 1, -1, 0, "after_to");
  endtask

  task automatic test_reset_mid;
    int d0, e0, b;
    ack_lat = 1;
    build(2, 2, 2, 2);
    issue(2, 2, 2, 2);
    stream = stream[0:4];
    feed(-1, 0, "mid");
    b = 0;
    while (!(stb && addr[31:30] == 2'b10) && b < 50) begin tick; b++; end
    d0 = dones; e0 = errs;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stb !== 1'b0) $display("FAIL mid_stb: got %b want 0", stb);
    else passed++;
    checks++;
    if ({addr, wdata, we, s_ready, busy, done, err, err_code} !== 71'b0)
      $display("FAIL mid_out: got %h %h %b%b%b%b%b %0d want 0",
               addr, wdata, we, s_ready, busy, done, err, err_code);
    else passed++;
    tick; tick; tick;
    rst_n = 1'b1;
    tick; tick;
    checks++;
    if (dones !== d0 || errs !== e0)
      $display("FAIL mid_pulse: got done=%0d err=%0d want 0 0", dones - d0, errs - e0);
    else passed++;
    run_cmd(1, 1, 1, 1, -1, 0, "after_rst");
  endtask

  task automatic test_random;
    int ra, ca, cb;
    for (int t = 0; t < 6; t++) begin
      ra = $urandom_range(1, 4);
      ca = $urandom_range(1, 4);
      cb = $urandom_range(1, 4);
      ack_lat = $urandom_range(1, 3);
      stray = 1'($urandom_range(0, 1));
      run_cmd(ra, ca, ca, cb, -1, 0, "rand");
    end
    stray = 1'b0;
    ack_lat = 1;
  endtask

  initial begin
    test_reset;
    test_idle_valid;
    ack_lat = 1;
    run_cmd(2, 2, 2, 2, -1, 0, "dir2x2");
    test_reject(2, 3, 2, 2, "cols_rows");
    test_reject(16, 2, 2, 2, "over_max");
    test_reject(0, 2, 2, 2, "zero_dim");
    test_timeout;
    ack_lat = 1;
    run_cmd(3, 3, 3, 2, 4, 10, "gap");
    run_cmd(15, 1, 1, 15, -1, 0, "max_a");
    run_cmd(1, 15, 15, 1, -1, 0, "max_b");
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
